// File: rtl/fft_pkg.sv
// Shared definitions for the frame FFT: FSM encoding, Q-format constant,
// integer log2 / bit-reverse helpers and elaboration-time twiddle generation.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fft_state_e;

    // Twiddles carry this many integer bits (sign included); the rest is fraction.
    localparam int Q_INT_BITS = 4;

    localparam real PI = 3.14159265358979323846;

    function automatic int q_frac(input int tw);
        return tw - Q_INT_BITS;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bitrev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r | (((v >> i) & 1) << (bits - 1 - i));
        end
        return r;
    endfunction

    // Power series keeps the twiddle tables foldable by any elaborator; angles stay in [0, pi].
    function automatic real taylor_cos(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i < 30; i++) begin
            term = -term * x * x / $itor((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real taylor_sin(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int i = 1; i < 30; i++) begin
            term = -term * x * x / $itor((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Component of W^k = cos(2*pi*k/n) - j*sin(2*pi*k/n), rounded to nearest in Q(tw-4).
    function automatic int twiddle(input int n, input int k, input int tw, input bit im);
        real ang;
        real v;
        real one;
        one = 1.0;
        for (int i = 0; i < q_frac(tw); i++) one = one * 2.0;
        ang = 2.0 * PI * $itor(k) / $itor(n);
        v   = im ? -taylor_sin(ang) : taylor_cos(ang);
        v   = v * one;
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIF butterfly: a = X+Y, b = (X-Y)*W, with optional
// halving, floor rounding of the product and saturation of every output.
module fft_bfly
    import fft_pkg::*;
#(
    parameter int DW    = 16,
    parameter int TW    = 20,
    parameter int SCALE = 0
) (
    input  logic [2*DW-1:0] x,
    input  logic [2*DW-1:0] y,
    input  logic [2*TW-1:0] w,
    output logic [2*DW-1:0] a,
    output logic [2*DW-1:0] b,
    output logic            ovf
);

    localparam int PW = DW + TW + 2;
    localparam int SH = q_frac(TW) + SCALE;
    localparam logic signed [PW-1:0] MAX_V = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic signed [PW-1:0] sext_d(input logic [DW-1:0] v);
        return {{(PW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] sext_w(input logic [TW-1:0] v);
        return {{(PW-TW){v[TW-1]}}, v};
    endfunction

    // Result is {saturated, clamped value}.
    function automatic logic [DW:0] sat(input logic signed [PW-1:0] v);
        if (v > MAX_V) return {1'b1, MAX_V[DW-1:0]};
        if (v < MIN_V) return {1'b1, MIN_V[DW-1:0]};
        return {1'b0, v[DW-1:0]};
    endfunction

    logic signed [PW-1:0] xr, xi, yr, yi, wr, wi;
    logic signed [PW-1:0] sum_r, sum_i, dif_r, dif_i, prd_r, prd_i;
    logic [DW:0] sat_ar, sat_ai, sat_br, sat_bi;

    always_comb begin
        xr    = sext_d(x[2*DW-1:DW]);
        xi    = sext_d(x[DW-1:0]);
        yr    = sext_d(y[2*DW-1:DW]);
        yi    = sext_d(y[DW-1:0]);
        wr    = sext_w(w[2*TW-1:TW]);
        wi    = sext_w(w[TW-1:0]);
        sum_r = (xr + yr) >>> SCALE;
        sum_i = (xi + yi) >>> SCALE;
        dif_r = xr - yr;
        dif_i = xi - yi;
        // One combined arithmetic shift equals floor by Q then floor by SCALE.
        prd_r = (dif_r * wr - dif_i * wi) >>> SH;
        prd_i = (dif_r * wi + dif_i * wr) >>> SH;
        sat_ar = sat(sum_r);
        sat_ai = sat(sum_i);
        sat_br = sat(prd_r);
        sat_bi = sat(prd_i);
        a   = {sat_ar[DW-1:0], sat_ai[DW-1:0]};
        b   = {sat_br[DW-1:0], sat_bi[DW-1:0]};
        ovf = sat_ar[DW] | sat_ai[DW] | sat_br[DW] | sat_bi[DW];
    end

endmodule

// File: rtl/fft_frame.sv
// Frame-based N-point FFT: fill N samples, run log2(N) in-place DIF stages with
// N/2 parallel butterflies (one stage per clock), then hold the natural-order result.
module fft_frame
    import fft_pkg::*;
#(
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int TW    = 20,
    parameter int SCALE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*DW-1:0]   fir_d,
    input  logic              fir_valid,
    output logic              fir_ready,
    output logic [N*2*DW-1:0] fft_d,
    output logic              fft_valid,
    input  logic              fft_ready,
    output logic              fft_ovf
);

    localparam int L  = clog2(N);
    localparam int NB = N / 2;
    localparam int SW = (L > 1) ? clog2(L) : 1;
    localparam int CW = 2 * DW;
    localparam logic [L-1:0]  CNT_LAST   = L'(N - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(L - 1);

    fft_state_e      state_q, state_d;
    logic [L-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [CW-1:0]   work_q [N];
    logic [CW-1:0]   work_d [N];
    logic [N*CW-1:0] fft_d_q, fft_d_d;
    logic            fft_valid_q, fft_valid_d;
    logic            fft_ovf_q, fft_ovf_d;

    logic [CW-1:0]   bf_a [NB];
    logic [CW-1:0]   bf_b [NB];
    logic [NB-1:0]   bf_ovf;
    logic [CW-1:0]   res [N];

    // Each butterfly sees a fixed, stage-indexed choice of operands and twiddle.
    for (genvar gi = 0; gi < NB; gi++) begin : g_bf
        logic [CW-1:0]   x_opt [L];
        logic [CW-1:0]   y_opt [L];
        logic [2*TW-1:0] w_opt [L];
        for (genvar gs = 0; gs < L; gs++) begin : g_st
            localparam int SPAN = N >> (gs + 1);
            localparam int TOP  = (gi / SPAN) * 2 * SPAN + (gi % SPAN);
            localparam int K    = (gi % SPAN) << gs;
            localparam int WR   = twiddle(N, K, TW, 1'b0);
            localparam int WI   = twiddle(N, K, TW, 1'b1);
            assign x_opt[gs] = work_q[TOP];
            assign y_opt[gs] = work_q[TOP + SPAN];
            assign w_opt[gs] = {WR[TW-1:0], WI[TW-1:0]};
        end
        fft_bfly #(
            .DW    (DW),
            .TW    (TW),
            .SCALE (SCALE)
        ) u_bfly (
            .x   (x_opt[stage_q]),
            .y   (y_opt[stage_q]),
            .w   (w_opt[stage_q]),
            .a   (bf_a[gi]),
            .b   (bf_b[gi]),
            .ovf (bf_ovf[gi])
        );
    end

    // Route butterfly outputs back to the slots they were read from.
    for (genvar gp = 0; gp < N; gp++) begin : g_wb
        logic [CW-1:0] r_opt [L];
        for (genvar gs = 0; gs < L; gs++) begin : g_st
            localparam int SPAN = N >> (gs + 1);
            localparam int BF   = (gp / (2 * SPAN)) * SPAN + (gp % SPAN);
            if ((gp % (2 * SPAN)) >= SPAN) begin : g_lo
                assign r_opt[gs] = bf_b[BF];
            end else begin : g_hi
                assign r_opt[gs] = bf_a[BF];
            end
        end
        assign res[gp] = r_opt[stage_q];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        work_d      = work_q;
        fft_d_d     = fft_d_q;
        fft_valid_d = fft_valid_q;
        fft_ovf_d   = fft_ovf_q;
        fir_ready   = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                fir_ready = 1'b1;
                if (fir_valid) begin
                    work_d[cnt_q] = fir_d;
                    cnt_d         = cnt_q + L'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RUN;
                        stage_d = '0;
                    end
                end
            end
            ST_RUN: begin
                for (int p = 0; p < N; p++) work_d[p] = res[p];
                if (|bf_ovf) fft_ovf_d = 1'b1;
                stage_d = stage_q + SW'(1);
                if (stage_q == STAGE_LAST) begin
                    stage_d = '0;
                    // DIF leaves bin k in slot bitrev(k).
                    for (int k = 0; k < N; k++) begin
                        fft_d_d[k*CW +: CW] = res[bitrev(k, L)];
                    end
                    fft_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fft_ready) begin
                    state_d     = ST_FILL;
                    cnt_d       = '0;
                    fft_valid_d = 1'b0;
                    fft_ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            stage_q     <= '0;
            fft_d_q     <= '0;
            fft_valid_q <= 1'b0;
            fft_ovf_q   <= 1'b0;
            for (int p = 0; p < N; p++) work_q[p] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            fft_d_q     <= fft_d_d;
            fft_valid_q <= fft_valid_d;
            fft_ovf_q   <= fft_ovf_d;
            work_q      <= work_d;
        end
    end

    assign fft_d     = fft_d_q;
    assign fft_valid = fft_valid_q;
    assign fft_ovf   = fft_ovf_q;

endmodule

// File: tb/tb_fft_frame.sv
// Directed bench for fft_frame: two instances (SCALE=0 and SCALE=1) share all
// stimulus and therefore stay in lockstep; each scenario checks the relevant one.
module tb_fft_frame;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int CW = 2 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [CW-1:0]   fir_d;
    logic            fir_valid;
    logic            fft_ready;
    logic            fir_ready0, fft_valid0, fft_ovf0;
    logic            fir_ready1, fft_valid1, fft_ovf1;
    logic [N*CW-1:0] fft_d0, fft_d1;

    fft_frame #(.N(N), .DW(DW), .TW(20), .SCALE(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .fir_d     (fir_d),
        .fir_valid (fir_valid),
        .fir_ready (fir_ready0),
        .fft_d     (fft_d0),
        .fft_valid (fft_valid0),
        .fft_ready (fft_ready),
        .fft_ovf   (fft_ovf0)
    );

    fft_frame #(.N(N), .DW(DW), .TW(20), .SCALE(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .fir_d     (fir_d),
        .fir_valid (fir_valid),
        .fir_ready (fir_ready1),
        .fft_d     (fft_d1),
        .fft_valid (fft_valid1),
        .fft_ready (fft_ready),
        .fft_ovf   (fft_ovf1)
    );

    int checks = 0;
    int errors = 0;
    int lat;
    logic [CW-1:0] frame [N];

    // 0x0400 * exp(+j*2*pi*n/16), rounded by hand.
    int tone_re [N] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                        -1024, -946, -724, -392, 0, 392, 724, 946};
    int tone_im [N] = '{0, 392, 724, 946, 1024, 946, 724, 392,
                        0, -392, -724, -946, -1024, -946, -724, -392};

    function automatic int bre(input logic [N*CW-1:0] d, input int k);
        logic signed [DW-1:0] v;
        v = d[k*CW+DW +: DW];
        return int'(v);
    endfunction

    function automatic int bim(input logic [N*CW-1:0] d, input int k);
        logic signed [DW-1:0] v;
        v = d[k*CW +: DW];
        return int'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        logic ok;
        ok = (obs >= exp - tol) && (obs <= exp + tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [DW-1:0] re, input logic [DW-1:0] im);
        for (int n = 0; n < N; n++) frame[n] = {re, im};
    endtask

    // Streams the frame; when wait_out is set, returns clocks from last accept to fft_valid.
    task automatic send_frame(input bit wait_out, output int latency);
        for (int n = 0; n < N; n++) begin
            check($sformatf("fir_ready_fill%0d", n), {31'd0, fir_ready0}, 32'd1);
            fir_d     = frame[n];
            fir_valid = 1'b1;
            step();
        end
        fir_valid = 1'b0;
        latency   = 0;
        if (wait_out) begin
            while (fft_valid0 !== 1'b1 && latency < 20) begin
                step();
                latency++;
            end
        end
    endtask

    task automatic handshake(input string tag);
        fft_ready = 1'b1;
        step();
        fft_ready = 1'b0;
        check({tag, "_valid_clr"}, {31'd0, fft_valid0}, 32'd0);
        check({tag, "_fill"}, {31'd0, fir_ready0}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        fir_d     = '0;
        fir_valid = 1'b0;
        fft_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", {31'd0, fft_valid0}, 32'd0);
        check("rst_ovf", {31'd0, fft_ovf0}, 32'd0);
        check("rst_d", {31'd0, (fft_d0 == '0)}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_fir_ready", {31'd0, fir_ready0}, 32'd1);
        check("rst_fir_ready_s1", {31'd0, fir_ready1}, 32'd1);
        step();

        // Impulse: every bin equals x[0].
        fill_const(16'h0000, 16'h0000);
        frame[0] = {16'h0100, 16'h0000};
        send_frame(1'b1, lat);
        check("imp_latency", lat, 32'd4);
        check("imp_ovf", {31'd0, fft_ovf0}, 32'd0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("imp_re%0d", k), bre(fft_d0, k), 32'h0100);
            check($sformatf("imp_im%0d", k), bim(fft_d0, k), 32'h0000);
        end

        // Backpressure: ten held clocks with fir_valid offered and ignored.
        fir_d     = 32'hDEADBEEF;
        fir_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("bp_valid%0d", c), {31'd0, fft_valid0}, 32'd1);
            check($sformatf("bp_fir_ready%0d", c), {31'd0, fir_ready0}, 32'd0);
            check($sformatf("bp_ovf%0d", c), {31'd0, fft_ovf0}, 32'd0);
            for (int k = 0; k < N; k++) begin
                check($sformatf("bp_bin%0d_%0d", k, c), fft_d0[k*CW +: CW], 32'h01000000);
            end
        end
        fir_valid = 1'b0;
        handshake("bp");

        // DC 0x0010: all energy in bin 0 = 16 * 0x0010.
        fill_const(16'h0010, 16'h0000);
        send_frame(1'b1, lat);
        check("dc_latency", lat, 32'd4);
        check("dc_bin0_re", bre(fft_d0, 0), 32'h0100);
        check("dc_bin0_im", bim(fft_d0, 0), 32'h0000);
        check("dc_ovf", {31'd0, fft_ovf0}, 32'd0);
        for (int k = 1; k < N; k++) begin
            check_near($sformatf("dc_re%0d", k), bre(fft_d0, k), 0, 1);
            check_near($sformatf("dc_im%0d", k), bim(fft_d0, k), 0, 1);
        end
        handshake("dc");

        // DC 0x0100: unscaled bin0 = 0x1000, scaled bin0 = 0x0100.
        fill_const(16'h0100, 16'h0000);
        send_frame(1'b1, lat);
        check("dcs_latency", lat, 32'd4);
        check("dcs_valid_s1", {31'd0, fft_valid1}, 32'd1);
        check("dcs_s0_bin0_re", bre(fft_d0, 0), 32'h1000);
        check("dcs_s1_bin0_re", bre(fft_d1, 0), 32'h0100);
        check("dcs_s1_bin0_im", bim(fft_d1, 0), 32'h0000);
        for (int k = 1; k < N; k++) begin
            check($sformatf("dcs_s1_re%0d", k), bre(fft_d1, k), 32'h0000);
            check($sformatf("dcs_s1_im%0d", k), bim(fft_d1, k), 32'h0000);
        end
        handshake("dcs");

        // Tone at bin 1 with scaling: bin1 ~ 0x0400, everything else ~ 0.
        for (int n = 0; n < N; n++) frame[n] = {16'(tone_re[n]), 16'(tone_im[n])};
        send_frame(1'b1, lat);
        check("tone_latency", lat, 32'd4);
        check("tone_s1_ovf", {31'd0, fft_ovf1}, 32'd0);
        for (int k = 0; k < N; k++) begin
            check_near($sformatf("tone_re%0d", k), bre(fft_d1, k), (k == 1) ? 1024 : 0, 4);
            check_near($sformatf("tone_im%0d", k), bim(fft_d1, k), 0, 4);
        end
        handshake("tone");

        // Full-scale DC saturates the unscaled instance only.
        fill_const(16'h7FFF, 16'h0000);
        send_frame(1'b1, lat);
        check("sat_latency", lat, 32'd4);
        check("sat_bin0_re", bre(fft_d0, 0), 32'h7FFF);
        check("sat_bin0_im", bim(fft_d0, 0), 32'h0000);
        check("sat_bin5_re", bre(fft_d0, 5), 32'h0000);
        check("sat_ovf", {31'd0, fft_ovf0}, 32'd1);
        check("sat_s1_bin0_re", bre(fft_d1, 0), 32'h7FFF);
        check("sat_s1_ovf", {31'd0, fft_ovf1}, 32'd0);
        repeat (3) step();
        check("sat_ovf_hold", {31'd0, fft_ovf0}, 32'd1);
        handshake("sat");
        check("sat_ovf_clr", {31'd0, fft_ovf0}, 32'd0);

        // Reset asserted while stage 2 is pending: everything clears at once.
        fill_const(16'h0000, 16'h0000);
        frame[0] = {16'h0200, 16'h0000};
        send_frame(1'b0, lat);
        step();
        step();
        check("mid_run_busy", {31'd0, fir_ready0}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, fft_valid0}, 32'd0);
        check("mid_rst_ovf", {31'd0, fft_ovf0}, 32'd0);
        check("mid_rst_d", {31'd0, (fft_d0 == '0)}, 32'd1);
        check("mid_rst_fir_ready", {31'd0, fir_ready0}, 32'd1);
        step();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("mid_no_valid%0d", c), {31'd0, fft_valid0}, 32'd0);
        end

        // Recovery frame, with fft_ready held high through FILL and RUN.
        fill_const(16'h0000, 16'h0000);
        frame[0]  = {16'h0040, 16'h0020};
        fft_ready = 1'b1;
        send_frame(1'b1, lat);
        check("rec_latency", lat, 32'd4);
        for (int k = 0; k < N; k++) begin
            check($sformatf("rec_bin%0d", k), fft_d0[k*CW +: CW], 32'h00400020);
        end
        step();
        fft_ready = 1'b0;
        check("rec_valid_clr", {31'd0, fft_valid0}, 32'd0);
        check("rec_fill", {31'd0, fir_ready0}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame.md
FFT_FRAME -- requirements
Module: fft_frame

Interface
REQ-001 SHALL have parameter N, default 16, meaning FFT points: power of 2, 4..64.
REQ-002 SHALL have parameter DW, default 16, meaning width of each real/imag component, two's complement.
REQ-003 SHALL have parameter TW, default 20, meaning twiddle component width, where 1.0 = 2^(TW-4).
REQ-004 SHALL have parameter SCALE, default 0, meaning that when 1, every butterfly output is arithmetically shifted right by 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port fir_d, input, 2*DW bits: input sample {real, imag}.
REQ-008 SHALL have port fir_valid, input, 1 bit: fir_d valid.
REQ-009 SHALL have port fir_ready, output, 1 bit: block accepts a sample.
REQ-010 SHALL have port fft_d, output, N*2*DW bits: bins in natural order, with bin k at bits [(k+1)*2*DW-1 : k*2*DW].
REQ-011 SHALL have port fft_valid, output, 1 bit: fft_d holds a complete frame.
REQ-012 SHALL have port fft_ready, input, 1 bit: consumer takes the frame.
REQ-013 SHALL have port fft_ovf, output, 1 bit: at least one saturation occurred in the current frame.

Function
REQ-014 SHALL implement FSM states FILL, RUN and HOLD, with FILL after reset.
REQ-015 SHALL, in FILL: drive fir_ready=1; accept a sample on each edge with fir_valid=1 into slot cnt; increment cnt; on the edge accepting slot N-1, enter RUN with stage=0.
REQ-016 SHALL ignore fir_valid in RUN and HOLD, with fir_ready=0 in both states.
REQ-017 SHALL, in RUN, perform one radix-2 DIF stage per clock in place on the working array using N/2 butterflies, with stage 0..L-1 where L=log2(N).
REQ-018 SHALL define stage s with span=N>>(s+1): pair (i, i+span) inside each group of 2*span, and twiddle index = (i mod span)<<s.
REQ-019 SHALL compute each butterfly as a=X+Y and b=(X-Y)*W^k, where W^k = cos(2πk/N) - j·sin(2πk/N), each component rounded to nearest in TW bits.
REQ-020 SHALL shift the complex product arithmetically right by TW-4 (floor), then apply the SCALE shift, then saturate to DW bits.
REQ-021 SHALL set fft_ovf sticky on any saturation and clear it on leaving HOLD.
REQ-022 SHALL, on the edge completing stage L-1, load fft_d with the bit-reversed working array reordered to natural order, enter HOLD, and assert fft_valid.
REQ-023 SHALL give a latency of exactly L clocks from the edge accepting sample N-1 to fft_valid=1.
REQ-024 SHALL, in HOLD, keep fft_d and fft_ovf stable; on an edge with fft_ready=1, go to FILL with cnt=0 and deassert fft_valid.
REQ-025 SHALL leave fft_d holding the last frame outside HOLD, and SHALL make it meaningful only while fft_valid=1.
REQ-026 SHALL make fft_ready in FILL or RUN have no effect.

Reset
REQ-027 SHALL, on rst=0, immediately and asynchronously force: state=FILL, cnt=0, stage=0, fft_valid=0, fft_ovf=0, fft_d=0, working array=0.
REQ-028 SHALL make fir_ready=1 the first output value after rst deasserts.
REQ-029 SHALL discard any partial frame or in-flight RUN interrupted by reset, with no output produced.

Structure
REQ-030 SHALL place the following in shared package fft_pkg: the twiddle-generation function (cos/sin rounded to TW bits), the log2 helper, and the Q-format constant TW-4.
REQ-031 SHALL implement the butterfly as sub-module fft_bfly (X, Y, W in; a, b, ovf out; combinational), instantiated N/2 times and time-multiplexed over stages.
REQ-032 SHALL implement the twiddle selection per butterfly as a stage-indexed constant table generated at elaboration.

Verification
REQ-033 SHALL cover this directed scenario (N=16, DW=16, SCALE=0): impulse x[0]=0x0100+j0, others 0 -> every bin 0x0100+j0, fft_ovf=0, fft_valid exactly 4 clocks after the 16th accept.
REQ-034 SHALL cover this directed scenario (N=16, DW=16, SCALE=0): DC, all samples 0x0010 -> bin0=0x0100+j0, bins 1..15 = 0 (±1 LSB).
REQ-035 SHALL cover this directed scenario (N=16, DW=16, SCALE=1): DC, all 0x0100 -> bin0=0x0100, others 0; tone x[n]=0x0400·W^-n -> bin1 ≈ 0x0400, others ≈ 0.
REQ-036 SHALL cover this directed scenario (N=16, DW=16): saturation, all samples 0x7FFF, SCALE=0 -> bin0 real=0x7FFF, fft_ovf=1; fft_ovf clears after the fft_ready handshake.
REQ-037 SHALL cover this directed scenario (N=16, DW=16): backpressure, fft_ready held 0 for 10 clocks in HOLD -> fft_d and fft_valid stable, fir_ready=0, fir_valid samples not accepted; fft_ready=1 -> FILL next clock.
REQ-038 SHALL cover this directed scenario (N=16, DW=16): rst pulsed low in the middle of RUN (stage 2) -> outputs zero immediately, no fft_valid; the next full frame computes correctly.
